// File: rtl/gray_frame_writer_pkg.sv
// gray_frame_writer_pkg: shared FSM state encoding, pixel byte type and FIFO depth for the gray frame writer
package gray_pkg;
  typedef enum logic [1:0] {
    GW_IDLE  = 2'b00,
    GW_RUN   = 2'b01,
    GW_DRAIN = 2'b10,
    GW_DONE  = 2'b11
  } gw_state_e;
  typedef logic [7:0] pixel_t;
  localparam int FIFO_DEPTH = 2;
endpackage

// File: rtl/gray_frame_writer_if.sv
// gray_frame_writer_if: pixel stream in (gs_valid/gs_data/gw_busy) and frame RAM write port (mem_we/mem_addr/mem_wdata/mem_wready)
//   master: producer + RAM side (drives gs_valid, gs_data, mem_wready)
//   slave : the writer (drives gw_busy, mem_we, mem_addr, mem_wdata)
interface gray_frame_writer_if #(parameter int ADDR_W = 8);
  import gray_pkg::*;
  logic              gs_valid;
  pixel_t            gs_data;
  logic              gw_busy;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  pixel_t            mem_wdata;
  logic              mem_wready;
  modport master (output gs_valid, gs_data, mem_wready, input gw_busy, mem_we, mem_addr, mem_wdata);
  modport slave  (input gs_valid, gs_data, mem_wready, output gw_busy, mem_we, mem_addr, mem_wdata);
endinterface

// File: rtl/gray_frame_writer_fifo2.sv
// gw_fifo2: 2-entry pixel FIFO; ports clk, rst_n (async low), clr_i (sync flush), push_i/din_i, pop_i/dout_o, full_o, empty_o
// Push while full is accepted only together with a pop; pop on empty is ignored.
module gw_fifo2 import gray_pkg::*; (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   clr_i,
  input  logic   push_i,
  input  logic   pop_i,
  input  pixel_t din_i,
  output pixel_t dout_o,
  output logic   full_o,
  output logic   empty_o
);
  pixel_t     mem_q [FIFO_DEPTH];
  logic       rd_q, wr_q;
  logic [1:0] cnt_q;
  logic       do_push, do_pop;
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign full_o  = cnt_q == 2'(FIFO_DEPTH);
  assign empty_o = cnt_q == 2'd0;
  assign dout_o  = mem_q[rd_q];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q  <= 1'b0;
      wr_q  <= 1'b0;
      cnt_q <= 2'd0;
    end else if (clr_i) begin
      rd_q  <= 1'b0;
      wr_q  <= 1'b0;
      cnt_q <= 2'd0;
    end else begin
      rd_q  <= rd_q ^ do_pop;
      wr_q  <= wr_q ^ do_push;
      cnt_q <= cnt_q + {1'b0, do_push} - {1'b0, do_pop};
    end
  end
  // Storage needs no reset: it is only observed while the count is non-zero.
  always_ff @(posedge clk) begin
    if (do_push && !clr_i) mem_q[wr_q] <= din_i;
  end
endmodule

// File: rtl/gray_frame_writer.sv
// gray_frame_writer: buffers gray pixel bytes and writes one N*M frame to RAM from BASE_ADDR
//   clk, rst_n (async low)     : clock and reset
//   gw_enable                  : start request, sampled in IDLE only
//   bus (slave)                : pixel stream in + RAM write port
//   gw_done                    : one-cycle pulse after the last pixel is written
//   overflow_err               : sticky, a byte was dropped while the FIFO was full
//   frame_sum (optional)       : mod-2^16 sum of written bytes, present with GRAY_FRAME_WRITER_CHECKSUM_EN
module gray_frame_writer import gray_pkg::*; #(
  parameter int N         = 2,
  parameter int M         = 2,
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic gw_enable,
  gray_frame_writer_if.slave bus,
  output logic gw_done,
  output logic overflow_err
`ifdef GRAY_FRAME_WRITER_CHECKSUM_EN
  ,
  output logic [15:0] frame_sum
`endif
);
  localparam int NM = N * M;
  localparam int CW = $clog2(NM + 1);
  localparam logic [CW-1:0] TOTAL = CW'(NM);
  localparam logic [CW-1:0] LAST  = CW'(NM - 1);
  gw_state_e   state_q, state_d;
  logic [CW-1:0] in_cnt_q, in_cnt_d, out_cnt_q, out_cnt_d;
  logic        ovf_q, ovf_d;
  logic        start, active, push, pop, we, full, empty;
  pixel_t      head;
  assign start  = state_q == GW_IDLE && gw_enable;
  assign active = state_q == GW_RUN || state_q == GW_DRAIN;
  assign we     = active && !empty;
  assign pop    = we && bus.mem_wready;
  // A full FIFO still takes a byte when the head leaves in the same cycle.
  assign push   = state_q == GW_RUN && bus.gs_valid && (!full || pop);
  gw_fifo2 u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (start),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   (bus.gs_data),
    .dout_o  (head),
    .full_o  (full),
    .empty_o (empty)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= GW_IDLE;
    else        state_q <= state_d;
  end
  // DRAIN leaves on the cycle the final write completes so gw_done follows it directly.
  always_comb begin
    state_d = state_q;
    case (state_q)
      GW_IDLE:  state_d = gw_enable ? GW_RUN : GW_IDLE;
      GW_RUN:   state_d = (push && in_cnt_q == LAST) ? GW_DRAIN : GW_RUN;
      GW_DRAIN: state_d = (out_cnt_q == TOTAL || (pop && out_cnt_q == LAST)) ? GW_DONE : GW_DRAIN;
      GW_DONE:  state_d = GW_IDLE;
    endcase
  end
  always_comb begin
    gw_done       = state_q == GW_DONE;
    bus.mem_we    = we;
    bus.mem_addr  = we ? ADDR_W'(BASE_ADDR) + ADDR_W'(out_cnt_q) : '0;
    bus.mem_wdata = we ? head : '0;
    bus.gw_busy   = full;
    overflow_err  = ovf_q;
  end
  always_comb begin
    in_cnt_d  = start ? '0 : in_cnt_q + CW'(push);
    out_cnt_d = start ? '0 : out_cnt_q + CW'(pop);
    ovf_d     = start ? 1'b0 : ovf_q | (state_q == GW_RUN && bus.gs_valid && !push);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
      ovf_q     <= 1'b0;
    end else begin
      in_cnt_q  <= in_cnt_d;
      out_cnt_q <= out_cnt_d;
      ovf_q     <= ovf_d;
    end
  end
`ifdef GRAY_FRAME_WRITER_CHECKSUM_EN
  logic [15:0] sum_q, sum_d;
  assign sum_d     = start ? 16'd0 : sum_q + (pop ? 16'(head) : 16'd0);
  assign frame_sum = sum_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sum_q <= 16'd0;
    else        sum_q <= sum_d;
  end
`endif
endmodule

// File: tb/tb_gray_frame_writer.sv
// tb_gray_frame_writer: scoreboard bench driving two writers (8-bit base 0x10, and 2-bit wrapping base 3) with the same stimulus
module tb_gray_frame_writer;
  import gray_pkg::*;
  logic   clk = 1'b0, rst_n = 1'b0, gw_enable = 1'b0;
  logic   gs_valid = 1'b0, wready = 1'b0;
  pixel_t gs_data = 8'h00;
  logic   done_a, ovf_a, done_b, ovf_b;
  int     checks = 0, errors = 0, cyc = 0, k = 0;
  logic [15:0] qa [$];
  logic [9:0]  qb [$];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  gray_frame_writer_if #(.ADDR_W(8)) ifa ();
  gray_frame_writer_if #(.ADDR_W(2)) ifb ();
  assign ifa.gs_valid   = gs_valid;
  assign ifa.gs_data    = gs_data;
  assign ifa.mem_wready = wready;
  assign ifb.gs_valid   = gs_valid;
  assign ifb.gs_data    = gs_data;
  assign ifb.mem_wready = wready;
`ifdef GRAY_FRAME_WRITER_CHECKSUM_EN
  logic [15:0] sum_a, sum_b;
`endif
  gray_frame_writer #(.N(2), .M(2), .ADDR_W(8), .BASE_ADDR(8'h10)) dut_a (
    .clk(clk), .rst_n(rst_n), .gw_enable(gw_enable), .bus(ifa),
    .gw_done(done_a), .overflow_err(ovf_a)
`ifdef GRAY_FRAME_WRITER_CHECKSUM_EN
    , .frame_sum(sum_a)
`endif
  );
  gray_frame_writer #(.N(2), .M(2), .ADDR_W(2), .BASE_ADDR(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .gw_enable(gw_enable), .bus(ifb),
    .gw_done(done_b), .overflow_err(ovf_b)
`ifdef GRAY_FRAME_WRITER_CHECKSUM_EN
    , .frame_sum(sum_b)
`endif
  );
  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", tag, obs, exp);
    end
  endtask
  task automatic expect_byte(pixel_t d);
    qa.push_back({8'h10 + 8'(k), d});
    qb.push_back({2'(3 + k), d});
    k++;
  endtask
  task automatic send(pixel_t d, bit acc);
    gs_valid = 1'b1;
    gs_data  = d;
    if (acc) expect_byte(d);
    @(posedge clk); #1;
    gs_valid = 1'b0;
  endtask
  task automatic start();
    k = 0;
    @(posedge clk); #1 gw_enable = 1'b1;
    @(posedge clk); #1 gw_enable = 1'b0;
  endtask
  int last_wr_a = -100;
  task automatic wait_done(int maxc);
    int dc;
    dc = -1;
    repeat (maxc) begin
      @(negedge clk);
      if (done_a) begin
        dc = cyc;
        break;
      end
    end
    check("done_seen", dc != -1, 1);
    check("done_b", done_b, done_a);
    check("done_lat", dc - last_wr_a, 1);
    @(negedge clk);
    check("done_pulse", {done_a, done_b}, 0);
    @(posedge clk); #1;
  endtask
  logic        hold_a = 1'b0, hold_b = 1'b0;
  logic [15:0] prev_a;
  logic [9:0]  prev_b;
  always @(negedge clk) begin
    if (!rst_n) hold_a = 1'b0;
    else begin
      if (hold_a) check("hold_a", {ifa.mem_we, ifa.mem_addr, ifa.mem_wdata}, {1'b1, prev_a});
      hold_a = ifa.mem_we && !ifa.mem_wready;
      prev_a = {ifa.mem_addr, ifa.mem_wdata};
      if (ifa.mem_we && ifa.mem_wready) begin
        last_wr_a = cyc;
        if (qa.size() == 0) check("unexp_wr_a", 1, 0);
        else check("wr_a", {ifa.mem_addr, ifa.mem_wdata}, qa.pop_front());
      end
    end
  end
  always @(negedge clk) begin
    if (!rst_n) hold_b = 1'b0;
    else begin
      if (hold_b) check("hold_b", {ifb.mem_we, ifb.mem_addr, ifb.mem_wdata}, {1'b1, prev_b});
      hold_b = ifb.mem_we && !ifb.mem_wready;
      prev_b = {ifb.mem_addr, ifb.mem_wdata};
      if (ifb.mem_we && ifb.mem_wready) begin
        if (qb.size() == 0) check("unexp_wr_b", 1, 0);
        else check("wr_b", {ifb.mem_addr, ifb.mem_wdata}, qb.pop_front());
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
  initial begin
    pixel_t t3 [4];
    int sent, ncyc, nd;
    bit seen;
    t3[0] = 8'h61; t3[1] = 8'h62; t3[2] = 8'h63; t3[3] = 8'h64;
    #1;
    check("rst_a", {ifa.gw_busy, ifa.mem_we, ifa.mem_addr, ifa.mem_wdata, done_a, ovf_a}, 0);
    check("rst_b", {ifb.gw_busy, ifb.mem_we, ifb.mem_addr, ifb.mem_wdata, done_b, ovf_b}, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    // basic frame, one extra beat lands in DRAIN and must be ignored
    start();
    wready = 1'b1;
    send(8'h11, 1); send(8'h22, 1); send(8'h33, 1); send(8'h44, 1);
    send(8'hEE, 0);
    wait_done(20);
    check("ovf_t1", {ovf_a, ovf_b}, 0);
    check("q_t1", qa.size() + qb.size(), 0);
    // backpressure: RAM stalled, third byte dropped
    start();
    check("ovf_clr", {ovf_a, ovf_b}, 0);
    wready = 1'b0;
    send(8'h51, 1); send(8'h52, 1);
    gs_valid = 1'b1; gs_data = 8'h53;
    @(negedge clk);
    check("busy", {ifa.gw_busy, ifb.gw_busy}, 2'b11);
    @(posedge clk); #1 gs_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    check("ovf_t2", {ovf_a, ovf_b}, 2'b11);
    wready = 1'b1;
    nd = 0;
    repeat (4) begin @(negedge clk); if (done_a || done_b) nd++; end
    check("no_done", nd, 0);
    check("q_t2", qa.size() + qb.size(), 0);
    check("idle_we", {ifa.mem_we, ifb.mem_we, ifa.gw_busy}, 0);
    @(posedge clk); #1;
    send(8'h54, 1); send(8'h55, 1);
    wait_done(20);
    check("ovf_sticky", {ovf_a, ovf_b}, 2'b11);
    // RAM ready toggling; producer honours gw_busy
    start();
    sent = 0; ncyc = 0; seen = 0;
    while (!seen && ncyc < 100) begin
      wready = ncyc[0];
      if (sent < 4 && !ifa.gw_busy) begin
        gs_valid = 1'b1;
        gs_data  = t3[sent];
        expect_byte(t3[sent]);
        sent++;
      end else gs_valid = 1'b0;
      @(posedge clk); #1;
      seen = done_a;
      ncyc++;
    end
    gs_valid = 1'b0;
    wready = 1'b1;
    check("t3_done", seen, 1);
    check("q_t3", qa.size() + qb.size(), 0);
    check("ovf_t3", {ovf_a, ovf_b}, 0);
    @(posedge clk); #1;
    // abort after two writes, then restart
    start();
    send(8'h71, 1); send(8'h72, 1);
    @(posedge clk); #1;
    check("q_abort", qa.size() + qb.size(), 0);
    rst_n = 1'b0;
    #1;
    check("abort_a", {ifa.gw_busy, ifa.mem_we, ifa.mem_addr, ifa.mem_wdata, done_a, ovf_a}, 0);
    check("abort_b", {ifb.gw_busy, ifb.mem_we, ifb.mem_addr, ifb.mem_wdata, done_b, ovf_b}, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    send(8'h7F, 0); send(8'h7E, 0);
    @(negedge clk);
    check("idle_ignore", {ifa.mem_we, ifb.mem_we, ifa.gw_busy}, 0);
    start();
    send(8'h81, 1); send(8'h82, 1); send(8'h83, 1); send(8'h84, 1);
    wait_done(20);
    // checksum frame
    start();
    send(8'hFF, 1); send(8'hFF, 1); send(8'h02, 1); send(8'h01, 1);
    wait_done(20);
`ifdef GRAY_FRAME_WRITER_CHECKSUM_EN
    check("sum_a", sum_a, 16'h0201);
    check("sum_b", sum_b, 16'h0201);
`endif
    check("q_end", qa.size() + qb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
